// File: rtl/adc_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : adc_sched_pkg
// Description : Shared types, default constants and flag indices for the
//               ADC conversion scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package adc_sched_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_DONE = 2'd2,
    CAPTURE   = 2'd3
  } sched_state_t;

  localparam int unsigned c_def_fifo_depth     = 4;
  localparam int unsigned c_def_start_cycles   = 4;
  localparam int unsigned c_def_timeout_cycles = 4096;
  localparam int unsigned c_def_period_w       = 16;
  localparam int unsigned c_data_w             = 16;

  localparam int unsigned c_flag_timeout  = 0;
  localparam int unsigned c_flag_missed   = 1;
  localparam int unsigned c_flag_overflow = 2;
  localparam int unsigned c_num_flags     = 3;

  typedef logic [c_num_flags-1:0] flags_t;

  // Sticky update: a set event in the clearing cycle still lands.
  function automatic flags_t next_flags(input flags_t cur, input flags_t set, input logic clr);
    return (clr ? '0 : cur) | set;
  endfunction

endpackage
`default_nettype wire

// File: rtl/adc_result_fifo.sv
`default_nettype none
// ============================================================================
// Module      : adc_result_fifo
// Description : First-word-fall-through result FIFO with level output.
// Revision    : 1.0 - initial release
// ============================================================================
module adc_result_fifo #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_push,
  input  logic [DATA_W-1:0]         i_push_data,
  input  logic                      i_pop,
  output logic [DATA_W-1:0]         o_rd_data,
  output logic                      o_full,
  output logic                      o_empty,
  output logic [$clog2(DEPTH):0]    o_level
);

  localparam int unsigned c_aw = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [c_aw:0] c_full_level = (c_aw + 1)'(DEPTH);
  localparam logic [c_aw:0] c_level_one  = (c_aw + 1)'(1);
  localparam logic [c_aw-1:0] c_ptr_one  = c_aw'(1);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [c_aw-1:0]   r_wr_ptr;
  logic [c_aw-1:0]   r_rd_ptr;
  logic [c_aw:0]     r_level;

  logic w_full;
  logic w_empty;
  logic w_do_pop;
  logic w_do_push;

  assign w_full    = (r_level == c_full_level);
  assign w_empty   = (r_level == '0);
  assign w_do_pop  = i_pop & ~w_empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_do_push = i_push & (~w_full | w_do_pop);

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + c_ptr_one;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + c_ptr_one;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + c_level_one;
        2'b01:   r_level <= r_level - c_level_one;
        default: r_level <= r_level;
      endcase
    end
  end

  assign o_rd_data = w_empty ? '0 : r_mem[r_rd_ptr];
  assign o_full    = w_full;
  assign o_empty   = w_empty;
  assign o_level   = r_level;

endmodule
`default_nettype wire

// File: rtl/adc_conv_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : adc_conv_scheduler
// Description : Periodic / single-shot ADC conversion sequencer with result
//               FIFO and sticky timeout, missed-trigger and overflow flags.
// Revision    : 1.0 - initial release
// ============================================================================
module adc_conv_scheduler
  import adc_sched_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH     = c_def_fifo_depth,
  parameter int unsigned START_CYCLES   = c_def_start_cycles,
  parameter int unsigned TIMEOUT_CYCLES = c_def_timeout_cycles,
  parameter int unsigned PERIOD_W       = c_def_period_w
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable_in,
  input  logic                          single_shot_in,
  input  logic [PERIOD_W-1:0]           period_in,
  input  logic                          clear_flags_in,
  output logic                          start_conversion_out,
  input  logic                          conversion_finished_in,
  input  logic [c_data_w-1:0]           result_in,
  output logic                          rd_valid_out,
  output logic [c_data_w-1:0]           rd_data_out,
  input  logic                          rd_ready_in,
  output logic                          busy_out,
  output logic                          timeout_out,
  output logic                          missed_trigger_out,
  output logic                          overflow_out,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_out
);

  localparam int unsigned c_tow = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [c_tow-1:0]    c_to_last    = c_tow'(TIMEOUT_CYCLES - 1);
  localparam logic [c_tow-1:0]    c_to_one     = c_tow'(1);
  localparam logic [3:0]          c_start_last = 4'(START_CYCLES - 1);
  localparam logic [PERIOD_W-1:0] c_period_one = PERIOD_W'(1);

  sched_state_t r_state;
  sched_state_t w_state_nxt;

  logic                r_done_meta;
  logic                r_done_s;
  logic                r_done_s_d;
  logic                w_done_rise;

  logic [PERIOD_W-1:0] r_period_cnt;
  logic                r_trigger;
  logic                w_req;

  logic [3:0]          r_start_cnt;
  logic [c_tow-1:0]    r_to_cnt;
  logic                r_start_out;

  logic                w_push;
  logic                w_timeout_hit;
  logic                w_missed_hit;
  logic                w_overflow_hit;
  flags_t              w_flag_set;
  flags_t              r_flags;

  logic                w_fifo_full;
  logic                w_fifo_empty;
  logic                w_fifo_pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_done_meta <= 1'b0;
      r_done_s    <= 1'b0;
      r_done_s_d  <= 1'b0;
    end else begin
      r_done_meta <= conversion_finished_in;
      r_done_s    <= r_done_meta;
      r_done_s_d  <= r_done_s;
    end
  end

  assign w_done_rise = r_done_s & ~r_done_s_d;

  // Trigger is registered so the first one lands a cycle after enable rises;
  // a zero period keeps the counter at 0 and triggers every enabled cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_period_cnt <= '0;
      r_trigger    <= 1'b0;
    end else if (!enable_in) begin
      r_period_cnt <= '0;
      r_trigger    <= 1'b0;
    end else if (r_period_cnt == '0) begin
      r_period_cnt <= period_in;
      r_trigger    <= 1'b1;
    end else begin
      r_period_cnt <= r_period_cnt - c_period_one;
      r_trigger    <= 1'b0;
    end
  end

  assign w_req = r_trigger | single_shot_in;

  always_comb begin
    w_state_nxt   = r_state;
    w_push        = 1'b0;
    w_timeout_hit = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_req) begin
          w_state_nxt = START;
        end
      end
      START: begin
        if (r_start_cnt == c_start_last) begin
          w_state_nxt = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (w_done_rise) begin
          w_state_nxt = CAPTURE;
        end else if (r_to_cnt == c_to_last) begin
          w_state_nxt   = IDLE;
          w_timeout_hit = 1'b1;
        end
      end
      CAPTURE: begin
        w_push      = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_start_cnt <= '0;
      r_to_cnt    <= '0;
      r_start_out <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_start_cnt <= (r_state == START) ? r_start_cnt + 4'd1 : 4'd0;
      r_to_cnt    <= (r_state == WAIT_DONE) ? r_to_cnt + c_to_one : '0;
      r_start_out <= (w_state_nxt == START);
    end
  end

  assign w_missed_hit   = (r_state != IDLE) &
                          ((r_trigger & (period_in != '0)) | single_shot_in);
  assign w_fifo_pop     = rd_ready_in & ~w_fifo_empty;
  assign w_overflow_hit = w_push & w_fifo_full & ~w_fifo_pop;

  always_comb begin
    w_flag_set                  = '0;
    w_flag_set[c_flag_timeout]  = w_timeout_hit;
    w_flag_set[c_flag_missed]   = w_missed_hit;
    w_flag_set[c_flag_overflow] = w_overflow_hit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flags <= '0;
    end else begin
      r_flags <= next_flags(r_flags, w_flag_set, clear_flags_in);
    end
  end

  adc_result_fifo #(
    .DATA_W (c_data_w),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (w_push),
    .i_push_data (result_in),
    .i_pop       (w_fifo_pop),
    .o_rd_data   (rd_data_out),
    .o_full      (w_fifo_full),
    .o_empty     (w_fifo_empty),
    .o_level     (fifo_level_out)
  );

  assign start_conversion_out = r_start_out;
  assign rd_valid_out         = ~w_fifo_empty;
  assign busy_out             = (r_state != IDLE);
  assign timeout_out          = r_flags[c_flag_timeout];
  assign missed_trigger_out   = r_flags[c_flag_missed];
  assign overflow_out         = r_flags[c_flag_overflow];

endmodule
`default_nettype wire

// File: tb/tb_adc_conv_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_adc_conv_scheduler
// Description : Scoreboard bench for adc_conv_scheduler with a simple ADC model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_adc_conv_scheduler;

  localparam int unsigned FIFO_DEPTH     = 4;
  localparam int unsigned START_CYCLES   = 4;
  localparam int unsigned TIMEOUT_CYCLES = 64;
  localparam int unsigned PERIOD_W       = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable_in = 1'b0;
  logic        single_shot_in = 1'b0;
  logic [15:0] period_in = '0;
  logic        clear_flags_in = 1'b0;
  logic        start_conversion_out;
  logic        conversion_finished_in = 1'b0;
  logic [15:0] result_in = '0;
  logic        rd_valid_out;
  logic [15:0] rd_data_out;
  logic        rd_ready_in = 1'b0;
  logic        busy_out;
  logic        timeout_out;
  logic        missed_trigger_out;
  logic        overflow_out;
  logic [2:0]  fifo_level_out;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          adc_delay = 0;
  int          last_width = 0;
  int          rise_stamp[$];
  logic [15:0] adc_q[$];
  logic [15:0] exp_q[$];

  adc_conv_scheduler #(
    .FIFO_DEPTH     (FIFO_DEPTH),
    .START_CYCLES   (START_CYCLES),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .PERIOD_W       (PERIOD_W)
  ) dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .enable_in              (enable_in),
    .single_shot_in         (single_shot_in),
    .period_in              (period_in),
    .clear_flags_in         (clear_flags_in),
    .start_conversion_out   (start_conversion_out),
    .conversion_finished_in (conversion_finished_in),
    .result_in              (result_in),
    .rd_valid_out           (rd_valid_out),
    .rd_data_out            (rd_data_out),
    .rd_ready_in            (rd_ready_in),
    .busy_out               (busy_out),
    .timeout_out            (timeout_out),
    .missed_trigger_out     (missed_trigger_out),
    .overflow_out           (overflow_out),
    .fifo_level_out         (fifo_level_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_single();
    single_shot_in = 1'b1;
    step();
    single_shot_in = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int k;
    k = 0;
    while (busy_out && k < budget) begin
      step();
      k++;
    end
    chk(name, busy_out, 1'b0);
  endtask

  task automatic wait_finished(input string name, input int budget);
    int k;
    k = 0;
    while (!conversion_finished_in && k < budget) begin
      step();
      k++;
    end
    chk(name, conversion_finished_in, 1'b1);
  endtask

  task automatic wait_rises(input string name, input int n, input int budget);
    int k;
    k = 0;
    while (rise_stamp.size() < n && k < budget) begin
      step();
      k++;
    end
    chk(name, (rise_stamp.size() >= n), 1'b1);
  endtask

  // Pops an expected result each time the DUT hands one over.
  task automatic scoreboard();
    logic [15:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && rd_valid_out && rd_ready_in) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL sb_unexpected: got 0x%0h, required no output", rd_data_out);
        end else begin
          e = exp_q.pop_front();
          chk("sb_data", rd_data_out, e);
        end
      end
    end
  endtask

  task automatic mon_start();
    logic prev;
    int   w;
    prev = 1'b0;
    w    = 0;
    forever begin
      @(negedge clk);
      if (start_conversion_out && !prev) rise_stamp.push_back(cyc);
      if (start_conversion_out) w++;
      else if (prev) begin
        last_width = w;
        w = 0;
      end
      prev = start_conversion_out;
    end
  endtask

  // ADC: finished drops on each start and rises adc_delay cycles later (0 = never).
  task automatic adc_model();
    logic [15:0] nxt;
    forever begin
      @(posedge start_conversion_out);
      conversion_finished_in = 1'b0;
      if (adc_delay != 0) begin
        nxt = (adc_q.size() != 0) ? adc_q.pop_front() : 16'hDEAD;
        repeat (adc_delay) @(negedge clk);
        result_in = nxt;
        conversion_finished_in = 1'b1;
      end
    end
  endtask

  task automatic watchdog();
    repeat (20000) @(posedge clk);
    $display("FAIL watchdog: got no completion, required finish within 20000 cycles");
    $fatal(1, "watchdog expired");
  endtask

  initial begin
    int base;
    int d1;
    int d2;
    fork
      scoreboard();
      mon_start();
      adc_model();
      watchdog();
    join_none

    // Reset state
    repeat (3) step();
    chk("rst_start", start_conversion_out, 1'b0);
    chk("rst_valid", rd_valid_out, 1'b0);
    chk("rst_data", rd_data_out, 16'h0);
    chk("rst_busy", busy_out, 1'b0);
    chk("rst_flags", {timeout_out, missed_trigger_out, overflow_out}, 3'b000);
    chk("rst_level", fifo_level_out, 3'd0);
    rst_n = 1'b1;
    step();

    // 1: single shot
    adc_delay = 40;
    adc_q.push_back(16'hA5C3);
    exp_q.push_back(16'hA5C3);
    pulse_single();
    chk("t1_busy", busy_out, 1'b1);
    wait_finished("t1_fin_wait", 200);
    step();
    step();
    chk("t1_valid_early", rd_valid_out, 1'b0);
    step();
    chk("t1_valid", rd_valid_out, 1'b1);
    chk("t1_data", rd_data_out, 16'hA5C3);
    chk("t1_busy_done", busy_out, 1'b0);
    chk("t1_start_width", last_width, 4);
    chk("t1_level", fifo_level_out, 3'd1);
    rd_ready_in = 1'b1;
    repeat (3) step();
    chk("t1_level_drained", fifo_level_out, 3'd0);
    chk("t1_sb_empty", exp_q.size(), 0);

    // 2: periodic, period 100
    period_in = 16'd100;
    adc_delay = 30;
    base = rise_stamp.size();
    adc_q.push_back(16'h1111); exp_q.push_back(16'h1111);
    adc_q.push_back(16'h2222); exp_q.push_back(16'h2222);
    adc_q.push_back(16'h3333); exp_q.push_back(16'h3333);
    enable_in = 1'b1;
    wait_rises("t2_rise_wait", base + 3, 400);
    enable_in = 1'b0;
    wait_idle("t2_idle_wait", 100);
    repeat (4) step();
    d1 = (rise_stamp.size() >= base + 3) ? rise_stamp[base+1] - rise_stamp[base] : -1;
    d2 = (rise_stamp.size() >= base + 3) ? rise_stamp[base+2] - rise_stamp[base+1] : -1;
    chk("t2_period_a", d1, 101);
    chk("t2_period_b", d2, 101);
    chk("t2_missed", missed_trigger_out, 1'b0);
    chk("t2_sb_empty", exp_q.size(), 0);

    // 3: missed triggers, period 10 with 50-cycle conversions
    period_in = 16'd10;
    adc_delay = 50;
    base = rise_stamp.size();
    adc_q.push_back(16'h0A01); exp_q.push_back(16'h0A01);
    adc_q.push_back(16'h0A02); exp_q.push_back(16'h0A02);
    adc_q.push_back(16'h0A03); exp_q.push_back(16'h0A03);
    enable_in = 1'b1;
    wait_rises("t3_rise_wait", base + 3, 600);
    enable_in = 1'b0;
    wait_idle("t3_idle_wait", 200);
    repeat (4) step();
    chk("t3_missed", missed_trigger_out, 1'b1);
    chk("t3_timeout", timeout_out, 1'b0);
    chk("t3_sb_empty", exp_q.size(), 0);
    clear_flags_in = 1'b1;
    step();
    clear_flags_in = 1'b0;
    chk("t3_missed_clr", missed_trigger_out, 1'b0);

    // 5: overflow with reader stalled
    rd_ready_in = 1'b0;
    adc_delay = 20;
    for (int i = 1; i <= 5; i++) begin
      adc_q.push_back(16'(i));
      if (i <= 4) exp_q.push_back(16'(i));
      pulse_single();
      wait_idle("t5_idle_wait", 100);
      if (i == 4) chk("t5_no_ovf_yet", overflow_out, 1'b0);
    end
    chk("t5_level_full", fifo_level_out, 3'd4);
    chk("t5_overflow", overflow_out, 1'b1);
    clear_flags_in = 1'b1;
    step();
    clear_flags_in = 1'b0;
    chk("t5_ovf_clr", overflow_out, 1'b0);
    adc_q.push_back(16'h0006);
    exp_q.push_back(16'h0006);
    pulse_single();
    wait_finished("t5_fin_wait", 100);
    step();
    step();
    rd_ready_in = 1'b1;
    step();
    rd_ready_in = 1'b0;
    chk("t5_pushpop_level", fifo_level_out, 3'd4);
    chk("t5_pushpop_ovf", overflow_out, 1'b0);
    rd_ready_in = 1'b1;
    repeat (8) step();
    chk("t5_level_drained", fifo_level_out, 3'd0);
    chk("t5_sb_empty", exp_q.size(), 0);

    // 4: timeout, plus single shot while busy
    adc_delay = 0;
    pulse_single();
    begin
      int k;
      k = 0;
      while (start_conversion_out && k < 20) begin
        step();
        k++;
      end
    end
    chk("t4_in_wait", {busy_out, start_conversion_out}, 2'b10);
    repeat (10) step();
    pulse_single();
    chk("t4_missed_busy", missed_trigger_out, 1'b1);
    repeat (52) step();
    chk("t4_timeout_early", timeout_out, 1'b0);
    chk("t4_busy_early", busy_out, 1'b1);
    step();
    chk("t4_timeout", timeout_out, 1'b1);
    chk("t4_idle", busy_out, 1'b0);
    chk("t4_level", fifo_level_out, 3'd0);

    // 6: reset in WAIT_DONE
    rd_ready_in = 1'b0;
    adc_delay = 20;
    adc_q.push_back(16'h7777);
    pulse_single();
    wait_idle("t6_idle_wait", 100);
    chk("t6_level_pre", fifo_level_out, 3'd1);
    adc_delay = 0;
    pulse_single();
    repeat (8) step();
    chk("t6_busy_pre", busy_out, 1'b1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("t6_start", start_conversion_out, 1'b0);
    chk("t6_busy", busy_out, 1'b0);
    chk("t6_valid", rd_valid_out, 1'b0);
    chk("t6_level", fifo_level_out, 3'd0);
    chk("t6_flags", {timeout_out, missed_trigger_out, overflow_out}, 3'b000);
    step();
    step();
    rst_n = 1'b1;
    step();
    chk("t6_busy_post", busy_out, 1'b0);
    chk("t6_flags_post", {timeout_out, missed_trigger_out, overflow_out}, 3'b000);
    adc_delay = 20;
    adc_q.push_back(16'h5A5A);
    exp_q.push_back(16'h5A5A);
    rd_ready_in = 1'b1;
    pulse_single();
    wait_idle("t6_recover_wait", 100);
    repeat (4) step();
    chk("t6_sb_empty", exp_q.size(), 0);
    chk("t6_level_post", fifo_level_out, 3'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
